// File: rtl/fsm_requester.sv
// Two-channel request generator for the req/gnt arbiter: queues jobs per channel and
// holds req for BURST_LEN granted cycles per job. Optional grant timeout: REQ_TIMEOUT_EN.
module fsm_requester #(
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_0,
  input  logic              push_1,
  input  logic              gnt_0,
  input  logic              gnt_1,
  output logic              req_0,
  output logic              req_1,
  output logic              done_0,
  output logic              done_1,
  output logic              ovf_0,
  output logic              ovf_1,
  output logic              err_0,
  output logic              err_1,
  output logic [PEND_W-1:0] pend_0,
  output logic [PEND_W-1:0] pend_1
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, RELEASE} state_t;

  localparam logic [7:0]        BURST_LAST = 8'(BURST_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX   = '1;

  logic [1:0]        push;
  logic [1:0]        gnt;
  logic [1:0]        req_vec;
  logic [1:0]        done_vec;
  logic [1:0]        ovf_vec;
  logic [1:0]        err_vec;
  logic [PEND_W-1:0] pend_vec [2];

  assign push = {push_1, push_0};
  assign gnt  = {gnt_1, gnt_0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    state_t            state_reg;
    logic [7:0]        burst_reg;
    logic [PEND_W-1:0] pend_reg;
    logic              req_reg;
    logic              done_reg;
    logic              ovf_reg;
    logic              burst_done;
    logic              timeout_hit;
    logic              job_end;

    // burst_done marks the granted cycle that completes the job's BURST_LEN count.
    always_comb begin
      burst_done = 1'b0;
      if (gnt[gi]) begin
        if (state_reg == REQ) begin
          burst_done = (BURST_LEN == 1);
        end else if (state_reg == HOLD) begin
          burst_done = (burst_reg == BURST_LAST);
        end
      end
    end

`ifdef REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tcnt_reg;
    logic            err_reg;

    assign timeout_hit = (state_reg == REQ) && !gnt[gi] &&
                         (tcnt_reg == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        tcnt_reg <= '0;
        err_reg  <= 1'b0;
      end else begin
        err_reg <= timeout_hit;
        if (state_reg == REQ && !gnt[gi] && !timeout_hit) begin
          tcnt_reg <= tcnt_reg + 1'b1;
        end else begin
          tcnt_reg <= '0;
        end
      end
    end

    assign err_vec[gi] = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err_vec[gi] = 1'b0;
`endif

    assign job_end = burst_done | timeout_hit;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_reg <= IDLE;
        burst_reg <= '0;
        pend_reg  <= '0;
        req_reg   <= 1'b0;
        done_reg  <= 1'b0;
        ovf_reg   <= 1'b0;
      end else begin
        done_reg <= burst_done;
        ovf_reg  <= 1'b0;

        // A push coinciding with a job end cancels out, even when full.
        if (push[gi] && !job_end) begin
          if (pend_reg == PEND_MAX) begin
            ovf_reg <= 1'b1;
          end else begin
            pend_reg <= pend_reg + 1'b1;
          end
        end else if (!push[gi] && job_end) begin
          pend_reg <= pend_reg - 1'b1;
        end

        case (state_reg)
          IDLE: begin
            if (pend_reg != '0) begin
              state_reg <= REQ;
              req_reg   <= 1'b1;
            end
          end
          REQ: begin
            if (gnt[gi]) begin
              burst_reg <= 8'd1;
              if (burst_done) begin
                state_reg <= RELEASE;
                req_reg   <= 1'b0;
              end else begin
                state_reg <= HOLD;
              end
            end else if (timeout_hit) begin
              state_reg <= RELEASE;
              req_reg   <= 1'b0;
            end
          end
          HOLD: begin
            if (gnt[gi]) begin
              if (burst_done) begin
                state_reg <= RELEASE;
                req_reg   <= 1'b0;
              end else begin
                burst_reg <= burst_reg + 8'd1;
              end
            end
          end
          RELEASE: begin
            // Wait for the arbiter to drop the grant before a new request.
            if (!gnt[gi]) begin
              state_reg <= IDLE;
              burst_reg <= '0;
            end
          end
          default: begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
          end
        endcase
      end
    end

    assign req_vec[gi]  = req_reg;
    assign done_vec[gi] = done_reg;
    assign ovf_vec[gi]  = ovf_reg;
    assign pend_vec[gi] = pend_reg;
  end

`ifndef REQ_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign req_0  = req_vec[0];
  assign req_1  = req_vec[1];
  assign done_0 = done_vec[0];
  assign done_1 = done_vec[1];
  assign ovf_0  = ovf_vec[0];
  assign ovf_1  = ovf_vec[1];
  assign err_0  = err_vec[0];
  assign err_1  = err_vec[1];
  assign pend_0 = pend_vec[0];
  assign pend_1 = pend_vec[1];

endmodule

// File: tb/tb_fsm_requester.sv
// Directed vector bench for fsm_requester (BURST_LEN=4, PEND_W=4, TIMEOUT=16).
module tb_fsm_requester;

  logic       clock = 1'b0;
  logic       reset;
  logic       push_0, push_1, gnt_0, gnt_1;
  logic       req_0, req_1, done_0, done_1, ovf_0, ovf_1, err_0, err_1;
  logic [3:0] pend_0, pend_1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       p0, p1, g0, g1;
    logic       r0, r1, d0, d1, o0, o1;
    logic [3:0] n0, n1;
  } vec_t;

  vec_t vecs[$];

  fsm_requester #(.BURST_LEN(4), .PEND_W(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .push_0(push_0), .push_1(push_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .req_0(req_0), .req_1(req_1), .done_0(done_0), .done_1(done_1),
    .ovf_0(ovf_0), .ovf_1(ovf_1), .err_0(err_0), .err_1(err_1),
    .pend_0(pend_0), .pend_1(pend_1)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic p0, p1, g0, g1, r0, r1, d0, d1, o0, o1,
                     input int n0, n1);
    vec_t v;
    v.p0 = p0; v.p1 = p1; v.g0 = g0; v.g1 = g1;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.o0 = o0; v.o1 = o1;
    v.n0 = 4'(n0); v.n1 = 4'(n1);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [31:0] outs();
    return {16'h0, req_0, req_1, done_0, done_1, ovf_0, ovf_1, err_0, err_1, pend_0, pend_1};
  endfunction

  task automatic step(input logic p0, p1, g0, g1);
    push_0 = p0; push_1 = p1; gnt_0 = g0; gnt_1 = g1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Single job on channel 0 with the grant tied high.
    add(1,0,1,0, 0,0,0,0,0,0, 1,0);
    add(0,0,1,0, 1,0,0,0,0,0, 1,0);
    add(0,0,1,0, 1,0,0,0,0,0, 1,0);
    add(0,0,1,0, 1,0,0,0,0,0, 1,0);
    add(0,0,1,0, 1,0,0,0,0,0, 1,0);
    add(0,0,1,0, 0,0,1,0,0,0, 0,0);
    add(0,0,1,0, 0,0,0,0,0,0, 0,0);
    add(0,0,0,0, 0,0,0,0,0,0, 0,0);
    add(0,0,0,0, 0,0,0,0,0,0, 0,0);
    // Grant pattern 1,0,0,1,1,1 while requesting: four granted cycles counted.
    add(1,0,0,0, 0,0,0,0,0,0, 1,0);
    add(0,0,0,0, 1,0,0,0,0,0, 1,0);
    add(0,0,1,0, 1,0,0,0,0,0, 1,0);
    add(0,0,0,0, 1,0,0,0,0,0, 1,0);
    add(0,0,0,0, 1,0,0,0,0,0, 1,0);
    add(0,0,1,0, 1,0,0,0,0,0, 1,0);
    add(0,0,1,0, 1,0,0,0,0,0, 1,0);
    add(0,0,1,0, 0,0,1,0,0,0, 0,0);
    add(0,0,0,0, 0,0,0,0,0,0, 0,0);
    // Sixteen pushes on channel 1 without grant: saturate at 15, one overflow.
    for (int k = 1; k <= 16; k++) begin
      add(0,1,0,0, 0,(k >= 2),0,0,0,(k == 16), 0,(k > 15) ? 15 : k);
    end
    // Grant the in-flight job; push lands on the completing cycle at full.
    add(0,0,0,1, 0,1,0,0,0,0, 0,15);
    add(0,0,0,1, 0,1,0,0,0,0, 0,15);
    add(0,0,0,1, 0,1,0,0,0,0, 0,15);
    add(0,1,0,1, 0,0,0,1,0,0, 0,15);
    // Grant held after completion: no new request until it falls.
    add(0,0,0,1, 0,0,0,0,0,0, 0,15);
    add(0,0,0,1, 0,0,0,0,0,0, 0,15);
    add(0,0,0,0, 0,0,0,0,0,0, 0,15);
    add(0,0,0,0, 0,1,0,0,0,0, 0,15);
    add(0,0,0,1, 0,1,0,0,0,0, 0,15);

    reset = 1'b1;
    push_0 = 0; push_1 = 0; gnt_0 = 0; gnt_1 = 0;
    #1;
    check("reset_state", outs(), 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].p0, vecs[i].p1, vecs[i].g0, vecs[i].g1);
      check($sformatf("vec%0d", i), outs(),
            {16'h0, vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1,
             vecs[i].o0, vecs[i].o1, 2'b00, vecs[i].n0, vecs[i].n1});
    end

    // Asynchronous reset while channel 1 is mid-burst with 15 jobs queued.
    #2 reset = 1'b1;
    #1;
    check("async_reset_req1", {31'h0, req_1}, 32'h0);
    check("async_reset_pend1", {28'h0, pend_1}, 32'h0);
    push_0 = 0; push_1 = 0; gnt_0 = 0; gnt_1 = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_held_state", outs(), 32'h0);

    // Operation resumes after reset.
    step(1,0,0,0);
    check("resume_push", {28'h0, pend_0}, 32'h1);
    step(0,0,0,0);
    check("resume_req", {30'h0, req_0, req_1}, 32'h2);

`ifdef REQ_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      step(0,0,0,0);
      check($sformatf("wait%0d", i), {28'h0, req_0, err_0, done_0, pend_0 == 4'd1}, 32'h9);
    end
    step(0,0,0,0);
    check("timeout", {24'h0, req_0, err_0, done_0, 1'b0, pend_0}, 32'h40);
    step(0,0,0,0);
    check("timeout_after", {24'h0, req_0, err_0, done_0, 1'b0, pend_0}, 32'h0);
`else
    for (int i = 1; i <= 120; i++) begin
      step(0,0,0,0);
      check($sformatf("wait%0d", i), {28'h0, req_0, err_0, done_0, pend_0 == 4'd1}, 32'h9);
    end
    for (int i = 1; i <= 3; i++) begin
      step(0,0,1,0);
      check($sformatf("late_gnt%0d", i), {28'h0, req_0, err_0, done_0, pend_0 == 4'd1}, 32'h9);
    end
    step(0,0,1,0);
    check("late_done", {24'h0, req_0, err_0, done_0, 1'b0, pend_0}, 32'h20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_requester.md
# fsm_requester

Client-side counterpart of the two-channel request/grant arbiter. It queues work items per channel, raises `req_0`/`req_1`, and holds each request through a fixed-length granted burst. It then releases and waits for the grant to drop before it requests again. It sits between local job sources and the arbiter `fsm`, driving that block's `req_*` inputs and consuming its `gnt_*` outputs.

## Interface
- `BURST_LEN`, 4: granted cycles consumed per job (1..255)
- `PEND_W`, 4: pending-job counter width; capacity 2^PEND_W−1
- `TIMEOUT`, 16: max cycles waiting for grant (used only with `REQ_TIMEOUT_EN`)

Ports:
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `push_0`, `push_1` in 1: enqueue one job on channel 0/1
- `gnt_0`, `gnt_1` in 1: grants from arbiter
- `req_0`, `req_1` out 1: registered requests to arbiter
- `done_0`, `done_1` out 1: one-cycle pulse per completed job
- `ovf_0`, `ovf_1` out 1: one-cycle pulse when a push is dropped because the counter is full
- `err_0`, `err_1` out 1: one-cycle timeout pulse; tied 0 without `REQ_TIMEOUT_EN`
- `pend_0`, `pend_1` out `PEND_W`: jobs queued, including the one in progress

## Operation
- Two identical, independent channel FSMs. All outputs are registered.
- States per channel:
  - IDLE: if `pend` > 0, go to REQ and assert `req`.
  - REQ: hold `req`. When `gnt`=1, go to HOLD with `burst` = 1; this first granted cycle counts.
  - HOLD: `req` stays 1. `burst` increments on every cycle where `gnt`=1; cycles with `gnt`=0 pause the count and `req` stays high. When `burst` reaches `BURST_LEN` on a granted cycle, deassert `req`, pulse `done`, decrement `pend`, and go to RELEASE.
  - RELEASE: `req`=0. When `gnt`=0, go to IDLE. A new request cannot be raised until the grant has been seen low.
- Pending counter:
  - push increments it.
  - Saturates at 2^PEND_W−1; a push when full produces `ovf` and the job is dropped.
  - Push and completion in the same cycle leave the count unchanged, including when full (no `ovf`).
- `gnt` seen in IDLE or RELEASE is ignored. A grant without a request is not an error.
- `BURST_LEN`=1: REQ goes directly to RELEASE on the first granted cycle.

## Timing
- Reset values:
  - `req_*`=0, `done_*`=0, `ovf_*`=0, `err_*`=0, `pend_*`=0
  - all FSMs in IDLE, burst/timeout counters 0
- Reset asserted mid-burst drops `req` immediately (asynchronously) and discards all queued jobs.
- Latency:
  - `push` at edge N with an empty counter gives `pend`=1 and `req`=1 after edge N+1.
  - The request is held until the `BURST_LEN`-th granted cycle.
  - `req` falls and `done` pulses at the edge that samples that cycle.
- Minimum gap between consecutive jobs is 2 cycles: RELEASE needs `gnt` low, then IDLE raises `req`.
- Channels never interact. Both may request in the same cycle; the arbiter resolves priority.

## Configuration
- `REQ_TIMEOUT_EN` defined:
  - A counter runs while in REQ.
  - If `TIMEOUT` cycles elapse without `gnt`: pulse `err`, drop `req`, decrement `pend` (the job is abandoned, no `done`), and go to RELEASE.
  - The counter clears when leaving REQ.
- `REQ_TIMEOUT_EN` undefined:
  - REQ waits indefinitely.
  - `err_*` are constant 0; no timeout counter is synthesized.

## Test plan
- Reset, one `push_0`, `gnt_0` tied 1 with BURST_LEN=4 → `req_0` high for exactly 4 granted cycles, one `done_0` pulse, `pend_0` goes 1→0, `req_1` stays 0 throughout.
- `gnt_0` pattern 1,0,0,1,1,1 during HOLD → `req_0` held for the full 6 cycles, then `done_0`; exactly 4 granted cycles are counted.
- 16 pushes on channel 1 with PEND_W=4 and no grant → `pend_1`=15, one `ovf_1` pulse; a push coincident with `done_1` at full produces no `ovf_1` and `pend_1` stays 15.
- `gnt_1` held high after completion → `req_1` stays 0 until `gnt_1` falls, then re-asserts 2 cycles later if `pend_1`>0.
- `REQ_TIMEOUT_EN` with TIMEOUT=16 and `gnt_0` held 0 → after 16 cycles in REQ, `err_0` pulses, `req_0` drops, `pend_0` decrements, no `done_0`. Without the macro, `req_0` stays high for 100+ cycles and `err_0`=0.
- `reset` asserted mid-HOLD → `req_*` and `pend_*` go to 0 without waiting for a clock edge; normal operation resumes after release.
